// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR tap-chain controller.
//   - state_e       : controller sequencing states (RUN, DRAIN, SWAP)
//   - DEF_DATA_WIDTH: default sample/coefficient/sum width
//   - DEF_NUM_TAPS  : default number of taps in the chain
//   - FRAC_BITS     : fraction bits of the default Q1.(DATA_WIDTH-1) format
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_TAPS   = 16;
  localparam int FRAC_BITS      = DEF_DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

endpackage

// File: rtl/fir_ctrl_out_fifo.sv
// fir_ctrl_out_fifo: 2-entry synchronous FIFO holding chain results until
// the downstream consumer takes them.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push         : write iv_push_data (ignored when full and not popping)
//   i_pop          : remove head entry (ignored when empty)
//   ov_count       : number of stored entries (0..2)
//   ov_head        : oldest entry; 0 after reset
module fir_ctrl_out_fifo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] iv_push_data,
  input  logic                  i_pop,
  output logic [1:0]            ov_count,
  output logic [DATA_WIDTH-1:0] ov_head
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign do_pop  = i_pop && (count_q != 2'd0);
  // A full FIFO can still accept a push in the cycle its head leaves.
  assign do_push = i_push && ((count_q != 2'd2) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        mem_q[gi] <= '0;
      end else if (do_push && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= iv_push_data;
      end
    end
  end

  assign ov_count = count_q;
  assign ov_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencing controller for a transposed-form FIR tap chain.
// Accepts samples over valid/ready, drives the chain enable and sample bus,
// holds a shadow/active coefficient pair swapped only while the chain is
// idle, and returns chain results through a 2-entry output buffer.
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_coef_wr/iv_coef_addr/iv_coef_data : shadow-bank write port
//   i_coef_commit, o_coef_busy: swap request pulse / swap in progress
//   i_s_valid/o_s_ready/iv_s_data       : input sample handshake
//   o_tap_en, ov_tap_din      : chain enable and sample
//   ov_weights                : active bank, h[k] at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_chain_clr               : synchronous clear to the chain
//   iv_chain_sum              : registered chain output
//   o_m_valid/i_m_ready/ov_m_data       : filtered output handshake
// Build option: define FIR_CTRL_CLR_ON_SWAP_EN to pulse o_chain_clr during
// the SWAP cycle so the new coefficients start with zero history.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int ADDR_W     = $clog2(NUM_TAPS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_coef_wr,
  input  logic [ADDR_W-1:0]              iv_coef_addr,
  input  logic [DATA_WIDTH-1:0]          iv_coef_data,
  input  logic                           i_coef_commit,
  output logic                           o_coef_busy,
  input  logic                           i_s_valid,
  output logic                           o_s_ready,
  input  logic [DATA_WIDTH-1:0]          iv_s_data,
  output logic                           o_tap_en,
  output logic [DATA_WIDTH-1:0]          ov_tap_din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_chain_clr,
  input  logic [DATA_WIDTH-1:0]          iv_chain_sum,
  output logic                           o_m_valid,
  input  logic                           i_m_ready,
  output logic [DATA_WIDTH-1:0]          ov_m_data
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   clr_q, clr_d;
  logic   pend_q;
  logic   accept, pop, swap;
  logic [2:0] occ;
  logic [1:0] fifo_count;
  logic [NUM_TAPS*DATA_WIDTH-1:0] shadow_q, active_q;

  // Occupancy the FIFO will have after this cycle's in-flight push and pop;
  // a new sample is only taken if its result is guaranteed a slot.
  assign occ       = {1'b0, fifo_count} + {2'b0, pend_q} - {2'b0, pop};
  assign o_s_ready = (state_q == ST_RUN) && !i_coef_commit && !clr_q && (occ < 3'd2);
  assign accept    = i_s_valid && o_s_ready;
  assign o_tap_en  = accept;
  assign ov_tap_din = iv_s_data;
  assign pop       = o_m_valid && i_m_ready;
  assign swap      = (state_q == ST_SWAP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (i_coef_commit) state_d = ST_DRAIN;
      ST_DRAIN: if (!pend_q) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    busy_d = (state_d != ST_RUN);
`ifdef FIR_CTRL_CLR_ON_SWAP_EN
    clr_d = (state_d == ST_SWAP);
`else
    clr_d = 1'b0;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      busy_q  <= 1'b0;
      clr_q   <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      pend_q  <= accept;
    end
  end

  // Per-tap address decode: out-of-range addresses match no tap and drop.
  // The swap reads shadow_q, so a same-cycle write lands in shadow only.
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
    logic wr_hit;
    assign wr_hit = i_coef_wr && (iv_coef_addr == ADDR_W'(gi));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        shadow_q[gi*DATA_WIDTH +: DATA_WIDTH] <= '0;
        active_q[gi*DATA_WIDTH +: DATA_WIDTH] <= '0;
      end else begin
        if (wr_hit) shadow_q[gi*DATA_WIDTH +: DATA_WIDTH] <= iv_coef_data;
        if (swap)   active_q[gi*DATA_WIDTH +: DATA_WIDTH] <= shadow_q[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  fir_ctrl_out_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_out_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (pend_q),
    .iv_push_data(iv_chain_sum),
    .i_pop       (pop),
    .ov_count    (fifo_count),
    .ov_head     (ov_m_data)
  );

  assign o_m_valid   = (fifo_count != 2'd0);
  assign o_coef_busy = busy_q;
  assign o_chain_clr = clr_q;
  assign ov_weights  = active_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed bench for fir_ctrl with a small behavioural
// transposed-form chain (6 taps, Q1.31) closing the loop on iv_chain_sum.
module tb_fir_ctrl;

  localparam int DW = 32;
  localparam int NT = 6;
  localparam int AW = 3;
`ifdef FIR_CTRL_CLR_ON_SWAP_EN
  localparam logic CLR_EXP = 1'b1;
`else
  localparam logic CLR_EXP = 1'b0;
`endif

  logic              i_clk, i_rst_n;
  logic              coef_wr, commit, busy;
  logic [AW-1:0]     coef_addr;
  logic [DW-1:0]     coef_data;
  logic              s_valid, s_ready, tap_en;
  logic [DW-1:0]     s_data, tap_din, chain_sum, m_data;
  logic [NT*DW-1:0]  weights;
  logic              chain_clr, m_valid, m_ready;

  int errors = 0;
  int checks = 0;
  int acc, rcv;

  fir_ctrl #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ADDR_W(AW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_coef_wr    (coef_wr),
    .iv_coef_addr (coef_addr),
    .iv_coef_data (coef_data),
    .i_coef_commit(commit),
    .o_coef_busy  (busy),
    .i_s_valid    (s_valid),
    .o_s_ready    (s_ready),
    .iv_s_data    (s_data),
    .o_tap_en     (tap_en),
    .ov_tap_din   (tap_din),
    .ov_weights   (weights),
    .o_chain_clr  (chain_clr),
    .iv_chain_sum (chain_sum),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .ov_m_data    (m_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Behavioural transposed-form chain: st[k] is the partial sum entering tap k.
  logic signed [DW-1:0] st [1:NT-1];

  function automatic logic signed [DW-1:0] qmul(input logic signed [DW-1:0] a,
                                               input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = a * b;
    return p[2*DW-2:DW-1];
  endfunction

  always @(posedge i_clk) begin
    if (chain_clr) begin
      chain_sum <= '0;
      for (int k = 1; k < NT; k++) st[k] <= '0;
    end else if (tap_en) begin
      chain_sum <= qmul(tap_din, weights[0 +: DW]) + st[1];
      for (int k = 1; k < NT; k++)
        st[k] <= qmul(tap_din, weights[k*DW +: DW]) + ((k == NT-1) ? '0 : st[(k == NT-1) ? k : k+1]);
    end
  end

  task automatic check(input string tag, input logic [NT*DW-1:0] obs, input logic [NT*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; coef_wr = 1'b0; coef_addr = '0; coef_data = '0; commit = 1'b0;
    s_valid = 1'b1; s_data = 32'h1234_5678; m_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_clr", chain_clr, 1'b1);
    check("rst_ready", s_ready, 1'b0);
    check("rst_tap_en", tap_en, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_weights", weights, '0);
    $display("reset: clr=%0b ready=%0b busy=%0b", chain_clr, s_ready, busy);

    // Release: clr holds until the next edge, then ready rises
    i_rst_n = 1'b1; s_valid = 1'b0;
    #1;
    check("rel_clr_hold", chain_clr, 1'b1);
    check("rel_ready_hold", s_ready, 1'b0);
    tick();
    check("rel_clr_fall", chain_clr, 1'b0);
    check("rel_ready_rise", s_ready, 1'b1);
    $display("release: clr=%0b ready=%0b", chain_clr, s_ready);

    // Load h0 = 1.0 and commit while idle
    coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 32'h7FFF_FFFF;
    tick();
    coef_wr = 1'b0;
    #1;
    check("shadow_only", weights, '0);
    commit = 1'b1;
    #1;
    check("commit_ready_drop", s_ready, 1'b0);
    tick();
    commit = 1'b0;
    #1;
    check("drain_busy", busy, 1'b1);
    tick();
    check("swap_busy", busy, 1'b1);
    check("swap_weights_old", weights, '0);
    check("swap_clr", chain_clr, CLR_EXP);
    tick();
    check("run_busy", busy, 1'b0);
    check("run_weights", weights, 192'h7FFF_FFFF);
    check("run_ready", s_ready, 1'b1);
    $display("commit1: busy=%0b weights=%0h", busy, weights);

    // Impulse 0.5 through h0 = 1.0
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_valid = (i < 4);
      s_data  = (i == 0) ? 32'h4000_0000 : 32'h0;
      #1;
      check("imp_tap_en", tap_en, s_valid);
      check("imp_m_valid", m_valid, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) check("imp_m_data", m_data, (i == 2) ? 32'h3FFF_FFFF : 32'h0);
      $display("impulse cyc=%0d tap_en=%0b m_valid=%0b m_data=%08h", i, tap_en, m_valid, m_data);
      tick();
    end
    s_valid = 1'b0;

    // Backpressure: exactly two samples accepted, head stable
    m_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h1000_0000 * (acc + 1);
      #1;
      check("bp_accept", tap_en, (i < 2));
      if (i >= 2) check("bp_hold", m_data, 32'h0FFF_FFFF);
      if (tap_en) acc++;
      $display("backpressure cyc=%0d ready=%0b m_valid=%0b m_data=%08h", i, s_ready, m_valid, m_data);
      tick();
    end
    check("bp_count", acc, 2);
    check("bp_ready_low", s_ready, 1'b0);
    check("bp_m_valid", m_valid, 1'b1);

    // Release backpressure: five samples in total, none lost
    m_ready = 1'b1; rcv = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = (acc < 5);
      s_data  = 32'h1000_0000 * (acc + 1);
      #1;
      if (m_valid) begin
        check("rel_data", m_data, 32'h1000_0000 * (rcv + 1) - 1);
        $display("drain out=%0d m_data=%08h", rcv, m_data);
        rcv++;
      end
      if (tap_en) acc++;
      tick();
    end
    s_valid = 1'b0;
    check("rel_rcv_count", rcv, 5);
    check("rel_acc_count", acc, 5);
    check("rel_empty", m_valid, 1'b0);

    // New shadow bank h0 = 0.5, h1 = 0.25, commit during streaming
    coef_wr = 1'b1; coef_addr = 3'd0; coef_data = 32'h4000_0000;
    tick();
    coef_addr = 3'd1; coef_data = 32'h2000_0000;
    tick();
    coef_wr = 1'b0;
    s_valid = 1'b1; s_data = 32'h4000_0000;
    #1;
    check("cs_c0_accept", tap_en, 1'b1);
    tick();
    commit = 1'b1;
    #1;
    check("cs_c1_ready", s_ready, 1'b0);
    check("cs_c1_tap_en", tap_en, 1'b0);
    tick();
    commit = 1'b0;
    #1;
    check("cs_c2_busy", busy, 1'b1);
    check("cs_c2_ready", s_ready, 1'b0);
    check("cs_c2_m_valid", m_valid, 1'b1);
    check("cs_c2_old_out", m_data, 32'h3FFF_FFFF);
    tick();
    check("cs_c3_busy", busy, 1'b1);
    check("cs_c3_clr", chain_clr, CLR_EXP);
    check("cs_c3_weights", weights, 192'h7FFF_FFFF);
    tick();
    check("cs_c4_busy", busy, 1'b0);
    check("cs_c4_clr", chain_clr, 1'b0);
    check("cs_c4_weights", weights, 192'h2000_0000_4000_0000);
    check("cs_c4_accept", tap_en, 1'b1);
    tick();
    s_data = 32'h0;
    #1;
    check("cs_c5_accept", tap_en, 1'b1);
    tick();
    s_valid = 1'b0;
    #1;
    check("cs_c6_m_valid", m_valid, 1'b1);
    check("cs_c6_new_out", m_data, 32'h2000_0000);
    tick();
    check("cs_c7_new_out", m_data, 32'h1000_0000);
    tick();
    check("cs_c8_empty", m_valid, 1'b0);
    $display("commit2: weights=%0h", weights);

    // Out-of-range write, then a second commit while busy
    coef_wr = 1'b1; coef_addr = 3'd6; coef_data = 32'hDEAD_BEEF;
    tick();
    coef_wr = 1'b0; commit = 1'b1;
    tick();
    check("oor_drain_busy", busy, 1'b1);
    tick();
    commit = 1'b0;
    #1;
    check("oor_swap_busy", busy, 1'b1);
    tick();
    check("oor_idle", busy, 1'b0);
    check("oor_weights", weights, 192'h2000_0000_4000_0000);
    tick();
    check("no_extra_swap", busy, 1'b0);
    $display("oor/double commit: busy=%0b weights=%0h", busy, weights);

    // Fill the FIFO, then assert reset mid-cycle
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h1000_0000;
    #1;
    tick();
    s_data = 32'h2000_0000;
    #1;
    tick();
    s_valid = 1'b0;
    #1;
    tick();
    check("full_m_valid", m_valid, 1'b1);
    check("full_ready", s_ready, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_m_data", m_data, '0);
    check("arst_weights", weights, '0);
    check("arst_clr", chain_clr, 1'b1);
    check("arst_ready", s_ready, 1'b0);
    $display("async reset: m_valid=%0b weights=%0h", m_valid, weights);
    tick();
    i_rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
